// File: rtl/ring_tdm_pkg.sv
// Shared constants and one-hot helpers for the ring-counter driven TDM mux.
// Optional phase-sequence checking is enabled by defining RING_TDM_SEQ_CHECK_EN.
package ring_tdm_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int N_CH_DEF   = 4;
   localparam int CH_W_DEF   = $clog2(N_CH_DEF);

   // True when exactly one bit of the (zero-extended) vector is set.
   function automatic logic onehot_ok(input logic [31:0] vec);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cnt += 32'(vec[i]);
      end
      return (cnt == 1);
   endfunction

   // Index of the highest set bit; meaningful only when onehot_ok(vec) holds.
   function automatic logic [4:0] onehot_idx(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_phase_check.sv
// Validates the ring-counter phase vector, decodes the active slot index and
// keeps the sticky phase error flag. With RING_TDM_SEQ_CHECK_EN defined it also
// requires each phase to be the previous phase rotated one step toward the MSB.
module ring_phase_check
   import ring_tdm_pkg::*;
#(
   parameter  int N_CH = N_CH_DEF,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] phase,
   input  logic            err_clr,
   output logic            phase_ok,
   output logic [CH_W-1:0] sel,
   output logic            phase_err
);

   logic one_hot;
   logic seq_ok;
   logic phase_err_d, phase_err_q;

   assign one_hot = onehot_ok(32'(phase));
   assign sel     = CH_W'(onehot_idx(32'(phase)));

`ifdef RING_TDM_SEQ_CHECK_EN
   logic [N_CH-1:0] prev_d, prev_q;
   logic            armed_d, armed_q;
   logic [N_CH-1:0] expect_phase;

   // Track the last phase and arm the sequence check once a well-formed phase is seen.
   always_comb begin
      prev_d       = phase;
      armed_d      = armed_q | one_hot;
      expect_phase = {prev_q[N_CH-2:0], prev_q[N_CH-1]};
      seq_ok       = ~armed_q | (phase == expect_phase);
   end

   // Sequence-check history registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
      end
   end
`else
   assign seq_ok = 1'b1;
`endif

   assign phase_ok = one_hot & seq_ok;

   // Sticky error: a new error outranks a simultaneous clear.
   always_comb begin
      phase_err_d = phase_err_q;
      if (err_clr)   phase_err_d = 1'b0;
      if (!phase_ok) phase_err_d = 1'b1;
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) phase_err_q <= 1'b0;
      else      phase_err_q <= phase_err_d;
   end

   assign phase_err = phase_err_q;

endmodule

// File: rtl/ring_tdm_mux.sv
// Time-division multiplexer: each channel owns one slot per ring revolution and
// drains its one-entry holding register onto a single registered output.
// Optional feature macro: RING_TDM_SEQ_CHECK_EN (phase sequence checking).
//
// Handshake: a word moves from channel i into hold[i] on a rising edge where
// in_valid[i] and in_ready[i] are both 1. in_ready[i] depends only on state and
// the current phase (never on in_valid), so offers may be held until accepted.
module ring_tdm_mux
   import ring_tdm_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int N_CH   = N_CH_DEF,
   localparam int CH_W   = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        phase,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH*DATA_W-1:0] in_data,
   output logic [N_CH-1:0]        in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [CH_W-1:0]        out_ch,
   output logic                   phase_err,
   input  logic                   err_clr
);

   logic              phase_ok;
   logic [CH_W-1:0]   sel;
   logic [N_CH-1:0]   drain;
   logic [N_CH-1:0]   xfer;

   logic [N_CH-1:0]   full_d, full_q;
   logic [DATA_W-1:0] hold_d [N_CH];
   logic [DATA_W-1:0] hold_q [N_CH];
   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] out_data_d, out_data_q;
   logic [CH_W-1:0]   out_ch_d, out_ch_q;

   ring_phase_check #(.N_CH(N_CH)) u_phase_check (
      .clk       (clk),
      .rst       (rst),
      .phase     (phase),
      .err_clr   (err_clr),
      .phase_ok  (phase_ok),
      .sel       (sel),
      .phase_err (phase_err)
   );

   // Slot decode and handshake: a draining channel can accept a refill on the same edge.
   always_comb begin
      drain    = phase_ok ? (phase & full_q) : '0;
      in_ready = {N_CH{rst}} & (~full_q | drain);
      xfer     = in_valid & in_ready;
   end

   // Holding registers: drain empties the slot, a same-edge transfer refills it.
   always_comb begin
      full_d = full_q;
      for (int i = 0; i < N_CH; i++) begin
         hold_d[i] = hold_q[i];
         if (drain[i]) full_d[i] = 1'b0;
         if (xfer[i]) begin
            full_d[i] = 1'b1;
            hold_d[i] = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output stage: a drain presents the old held word; otherwise data/index hold.
   always_comb begin
      out_valid_d = |drain;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (|drain) begin
         out_data_d = hold_q[sel];
         out_ch_d   = sel;
      end
   end

   // State registers; reset discards any held words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
      end else begin
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_ring_tdm_mux.sv
// Bench for ring_tdm_mux: directed scenarios plus randomized traffic checked
// against a slot-level behavioural model and an expected-output queue.
module tb_ring_tdm_mux;

   localparam int DATA_W = 8;
   localparam int N_CH   = 4;
   localparam int W      = 10;   // {ch[1:0], data[7:0]}

   logic                   clk;
   logic                   rst;
   logic [N_CH-1:0]        phase;
   logic [N_CH-1:0]        in_valid;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic [1:0]             out_ch;
   logic                   phase_err;
   logic                   err_clr;

   int n_checks = 0;
   int n_err    = 0;

   // model state
   bit          m_full [N_CH];
   logic [7:0]  m_hold [N_CH];
   bit          m_err;
   bit          m_out_valid;
   logic [7:0]  m_out_data;
   logic [1:0]  m_out_ch;
   logic [3:0]  m_prev;
   bit          m_armed;
   logic [W-1:0] exp_q[$];

   ring_tdm_mux dut (
      .clk       (clk),
      .rst       (rst),
      .phase     (phase),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .phase_err (phase_err),
      .err_clr   (err_clr)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] rot(input logic [3:0] p);
      return {p[2:0], p[3]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_full[i] = 0;
         m_hold[i] = 8'h00;
      end
      m_err       = 0;
      m_out_valid = 0;
      m_out_data  = 8'h00;
      m_out_ch    = 2'd0;
      m_prev      = 4'h0;
      m_armed     = 0;
      exp_q.delete();
   endtask

   task automatic set_data(input int ch, input logic [7:0] v);
      in_data[ch*DATA_W +: DATA_W] = v;
   endtask

   // One clock: called just after an edge with the next inputs already driven.
   task automatic cycle();
      logic [3:0] ready;
      logic [3:0] drain;
      bit         good;
      int         sel;
      logic [W-1:0] w;
      #1;
      good = ($countones(phase) == 1);
`ifdef RING_TDM_SEQ_CHECK_EN
      if (m_armed && phase != rot(m_prev)) good = 0;
`endif
      sel = 0;
      for (int i = 0; i < N_CH; i++) if (phase[i]) sel = i;
      for (int i = 0; i < N_CH; i++) begin
         drain[i] = good && phase[i] && m_full[i];
         ready[i] = !m_full[i] || drain[i];
      end
      chk("in_ready", 32'(in_ready), 32'(ready));
      m_out_valid = (drain != 4'h0);
      if (m_out_valid) exp_q.push_back({2'(sel), m_hold[sel]});
      for (int i = 0; i < N_CH; i++) begin
         if (drain[i]) m_full[i] = 0;
         if (in_valid[i] && ready[i]) begin
            m_full[i] = 1;
            m_hold[i] = in_data[i*DATA_W +: DATA_W];
         end
      end
      if (!good)        m_err = 1;
      else if (err_clr) m_err = 0;
      if ($countones(phase) == 1) m_armed = 1;
      m_prev = phase;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_out_valid));
      if (m_out_valid) begin
         w = exp_q.pop_front();
         m_out_data = w[7:0];
         m_out_ch   = w[9:8];
      end
      chk("out_data", 32'(out_data), 32'(m_out_data));
      chk("out_ch", 32'(out_ch), 32'(m_out_ch));
      chk("phase_err", 32'(phase_err), 32'(m_err));
   endtask

   task automatic rot_cycle();
      phase = rot(phase);
      cycle();
   endtask

   // Asynchronous reset held for two edges, checked while asserted.
   task automatic do_reset();
      rst      = 1'b0;
      in_valid = 4'hF;
      err_clr  = 1'b0;
      model_reset();
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_ch", 32'(out_ch), 32'h0);
      chk("rst_phase_err", 32'(phase_err), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_in_ready", 32'(in_ready), 32'h0);
      chk("rst_hold_out_valid", 32'(out_valid), 32'h0);
      in_valid = 4'h0;
      rst      = 1'b1;
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 32'hF);
   endtask

   initial begin
      rst      = 1'b1;
      phase    = 4'b0001;
      in_valid = 4'h0;
      in_data  = '0;
      err_clr  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // single word on ch2
      phase = 4'b0001;
      in_valid = 4'b0100;
      set_data(2, 8'hA5);
      cycle();
      in_valid = 4'h0;
      rot_cycle();
      rot_cycle();
      chk("single_valid", 32'(out_valid), 32'h1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_ch", 32'(out_ch), 32'h2);
      rot_cycle();

      // full rate on every channel
      for (int i = 0; i < N_CH; i++) set_data(i, 8'(8'h10 + i));
      in_valid = 4'hF;
      repeat (12) rot_cycle();
      in_valid = 4'h0;
      repeat (4) rot_cycle();

      // backpressure on ch1
      while (phase != 4'b0010) rot_cycle();
      rot_cycle();
      in_valid = 4'b0010;
      set_data(1, 8'h33);
      cycle();
      set_data(1, 8'h44);
      while (phase != 4'b0001) rot_cycle();
      rot_cycle();
      in_valid = 4'h0;
      chk("bp_drain_data", 32'(out_data), 32'h33);
      repeat (4) rot_cycle();

      // phase errors and clearing
      phase = 4'b0000;
      cycle();
      phase = 4'b0110;
      cycle();
      chk("err_sticky", 32'(phase_err), 32'h1);
      phase = 4'b0001;
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      rot_cycle();
      phase = 4'b1100;
      err_clr = 1'b1;
      cycle();
      chk("err_wins_over_clr", 32'(phase_err), 32'h1);
      err_clr = 1'b0;
      do_reset();

      // slot jump 0001 -> 0100 with ch2 full
      in_valid = 4'b0100;
      set_data(2, 8'h5C);
      phase = 4'b0001;
      cycle();
      in_valid = 4'h0;
      phase = 4'b0100;
      cycle();
      phase = 4'b1000;
      cycle();
      do_reset();

      // reset mid-operation discards held words
      phase = 4'b0001;
      in_valid = 4'b1110;
      for (int i = 0; i < N_CH; i++) set_data(i, 8'(8'hC0 + i));
      cycle();
      in_valid = 4'h0;
      do_reset();
      phase = 4'b0001;
      repeat (5) rot_cycle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 149) begin
            do_reset();
            phase = 4'b0001;
         end
         if ($urandom_range(0, 19) == 0) phase = 4'($urandom_range(0, 15));
         else if ($countones(phase) == 1) phase = rot(phase);
         else phase = 4'b0001;
         in_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < N_CH; i++) set_data(i, 8'($urandom_range(0, 255)));
         err_clr = ($urandom_range(0, 9) == 0);
         cycle();
      end
      err_clr = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
